// File: rtl/qsn_pkg.sv
// Shared constants, FSM states and shift-code helper
// for the Pc=5, q=3 QSN shifter front end.
package qsn_pkg;

  localparam int PC        = 5;
  localparam int Q         = 3;
  localparam int SEL_W     = 3;
  localparam int MERGE_W   = 4;
  localparam int COL_NUM   = 4;
  localparam int LAYER_NUM = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } qsn_state_e;

  // Returns {left_sel, right_sel, merge_sel} for effective shift e.
  // Lane 4 always comes from the right network, so only 4 merge bits.
  function automatic logic [2*SEL_W+MERGE_W-1:0] qsn_codes(
    input logic [SEL_W-1:0] e
  );
    logic [SEL_W-1:0]   r;
    logic [MERGE_W-1:0] m;
    r = (e == '0) ? '0 : SEL_W'(PC - int'(e));
    for (int k = 0; k < MERGE_W; k++) begin
      m[k] = (k < PC - int'(e));
    end
    return {e, r, m};
  endfunction

endpackage

// File: rtl/qsn_lane2plane.sv
// Lane-major to bit-plane transpose (combinational).
// Ports: msg_i lane k = msg_i[3k+2:3k]; bitN_o[k] = lane k bit N.
module qsn_lane2plane
  import qsn_pkg::*;
(
  input  logic [PC*Q-1:0] msg_i,
  output logic [PC-1:0]   bit0_o,
  output logic [PC-1:0]   bit1_o,
  output logic [PC-1:0]   bit2_o
);

  always_comb begin
    bit0_o = '0;
    bit1_o = '0;
    bit2_o = '0;
    for (int k = 0; k < PC; k++) begin
      bit0_o[k] = msg_i[Q*k];
      bit1_o[k] = msg_i[Q*k+1];
      bit2_o[k] = msg_i[Q*k+2];
    end
  end

endmodule

// File: rtl/qsn_ctrl_pc5_q3.sv
// Control/feed stage for the Pc=5, q=3 QSN cyclic shifter.
// Ports: beat in (in_valid/in_ready/in_msg/in_shift/in_dir),
//   bit-planes + left/right/merge selects to the shifter,
//   qsn_valid/col/layer/last tags at shifter output, sticky shift_err.
module qsn_ctrl_pc5_q3
  import qsn_pkg::*;
(
  input  logic        sys_clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [14:0] in_msg,
  input  logic [2:0]  in_shift,
  input  logic        in_dir,
  output logic [4:0]  sw_in_bit0,
  output logic [4:0]  sw_in_bit1,
  output logic [4:0]  sw_in_bit2,
  output logic [2:0]  left_sel,
  output logic [2:0]  right_sel,
  output logic [3:0]  merge_sel,
  output logic        qsn_valid,
  output logic [1:0]  qsn_col,
  output logic [1:0]  qsn_layer,
  output logic        qsn_last,
  output logic        shift_err
);

  localparam logic [1:0] COL_LAST = 2'(COL_NUM - 1);
  localparam logic [1:0] LAY_LAST = 2'(LAYER_NUM - 1);

  qsn_state_e  state_q;
  logic [1:0]  drain_q;
  logic        rdy_q;
  logic        err_q;
  logic [1:0]  col_q;
  logic [1:0]  layer_q;

  // stage 1: captured beat, merge_sel already driven
  logic [14:0] msg1_q;
  logic [2:0]  left1_q;
  logic [2:0]  right1_q;
  logic [3:0]  merge_q;
  logic        v1_q;
  logic [1:0]  c1_q;
  logic [1:0]  l1_q;

  // stage 2: data and left/right to shifter
  logic [4:0]  sw0_q;
  logic [4:0]  sw1_q;
  logic [4:0]  sw2_q;
  logic [2:0]  left_q;
  logic [2:0]  right_q;
  logic        v2_q;
  logic [1:0]  c2_q;
  logic [1:0]  l2_q;

  // stage 3: aligned with shifter registered output
  logic        qv_q;
  logic [1:0]  qc_q;
  logic [1:0]  ql_q;
  logic        qlast_q;

  logic        acc;
  logic        final_beat;
  logic [2:0]  e_fwd;
  logic [2:0]  e_eff;
  logic [9:0]  codes;
  logic [4:0]  p0;
  logic [4:0]  p1;
  logic [4:0]  p2;

  assign acc        = in_valid & rdy_q;
  assign final_beat = (col_q == COL_LAST) && (layer_q == LAY_LAST);

  // Illegal 5..7 fold back by one period.
  assign e_fwd = (in_shift >= 3'd5) ? in_shift - 3'd5 : in_shift;
  assign e_eff = (in_dir && e_fwd != 3'd0) ? 3'd5 - e_fwd : e_fwd;
  assign codes = qsn_codes(e_eff);

  qsn_lane2plane u_l2p (
    .msg_i  (msg1_q),
    .bit0_o (p0),
    .bit1_o (p1),
    .bit2_o (p2)
  );

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      drain_q  <= '0;
      rdy_q    <= 1'b0;
      err_q    <= 1'b0;
      col_q    <= '0;
      layer_q  <= '0;
      msg1_q   <= '0;
      left1_q  <= '0;
      right1_q <= '0;
      merge_q  <= '0;
      v1_q     <= 1'b0;
      c1_q     <= '0;
      l1_q     <= '0;
      sw0_q    <= '0;
      sw1_q    <= '0;
      sw2_q    <= '0;
      left_q   <= '0;
      right_q  <= '0;
      v2_q     <= 1'b0;
      c2_q     <= '0;
      l2_q     <= '0;
      qv_q     <= 1'b0;
      qc_q     <= '0;
      ql_q     <= '0;
      qlast_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_q <= RUN;
          rdy_q   <= 1'b1;
        end
        RUN: begin
          if (acc && final_beat) begin
            state_q <= DRAIN;
            rdy_q   <= 1'b0;
            drain_q <= '0;
          end
        end
        DRAIN: begin
          if (drain_q == 2'd2) begin
            state_q <= RUN;
            rdy_q   <= 1'b1;
          end else begin
            drain_q <= drain_q + 2'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          rdy_q   <= 1'b0;
        end
      endcase

      if (acc) begin
        col_q <= (col_q == COL_LAST) ? '0 : col_q + 2'd1;
        if (col_q == COL_LAST) begin
          layer_q <= (layer_q == LAY_LAST) ? '0 : layer_q + 2'd1;
        end
        if (in_shift >= 3'd5) begin
          err_q <= 1'b1;
        end
        msg1_q   <= in_msg;
        left1_q  <= codes[9:7];
        right1_q <= codes[6:4];
        merge_q  <= codes[3:0];
        c1_q     <= col_q;
        l1_q     <= layer_q;
      end
      v1_q <= acc;

      if (v1_q) begin
        sw0_q   <= p0;
        sw1_q   <= p1;
        sw2_q   <= p2;
        left_q  <= left1_q;
        right_q <= right1_q;
        c2_q    <= c1_q;
        l2_q    <= l1_q;
      end
      v2_q <= v1_q;

      qv_q    <= v2_q;
      qc_q    <= v2_q ? c2_q : '0;
      ql_q    <= v2_q ? l2_q : '0;
      qlast_q <= v2_q && (c2_q == COL_LAST);
    end
  end

  assign in_ready   = rdy_q;
  assign shift_err  = err_q;
  assign merge_sel  = merge_q;
  assign sw_in_bit0 = sw0_q;
  assign sw_in_bit1 = sw1_q;
  assign sw_in_bit2 = sw2_q;
  assign left_sel   = left_q;
  assign right_sel  = right_q;
  assign qsn_valid  = qv_q;
  assign qsn_col    = qc_q;
  assign qsn_layer  = ql_q;
  assign qsn_last   = qlast_q;

endmodule
